alu_pipe: RTL and testbench

- Parametrised, registered successor to the 4-bit combinational ALU.
- Operands and opcode are accepted over a valid/ready input handshake; the result and flags are delivered over a valid/ready output handshake.
- Adds XOR, shifts, a multi-cycle shift-add multiply, status flags and an error flag for illegal opcodes.
- Sits between the operand register file and the writeback stage.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_pipe_if.sv | 33 +++
 rtl/alu_mul_seq.sv | 59 +++++
 rtl/alu_pipe.sv | 163 ++++++++++++++++
 tb/tb_alu_pipe.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Opcode and FSM state encodings shared by the pipelined ALU.
// Revision: 1.0
// ============================================================================
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_NOT = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_pipe_if
// Operand/opcode input handshake and result/flag output handshake.
// Revision: 1.0
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              a;
    logic [WIDTH-1:0]              b;
    logic [alu_pkg::OPCODE_W-1:0]  opcode;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH-1:0]              result;
    logic                          carry_out;
    logic                          zero;
    logic                          ovf;
    logic                          err;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, carry_out, zero, ovf, err
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, carry_out, zero, ovf, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module : alu_mul_seq
// Iterative shift-add multiplier, one partial product per cycle.
// Revision: 1.0
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;

    // product_o includes the current iteration so the caller can capture it on done_o
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module : alu_pipe
// Registered ALU with valid/ready handshakes, flags and iterative multiply.
// Optional: define ALU_SAT_EN for saturating ADD/SUB.
// Revision: 1.0
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e               state_q, state_d;
    logic                 in_ready;
    logic                 accept;
    logic                 is_mul;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_e;

    logic [WIDTH-1:0]     result_q;
    logic                 carry_q;
    logic                 zero_q;
    logic                 ovf_q;
    logic                 err_q;

    assign is_mul    = (bus.opcode == OP_MUL);
    assign accept    = bus.in_valid && in_ready;
    assign mul_start = accept && is_mul;

    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                alu_c = sum[WIDTH];
                alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
`ifdef ALU_SAT_EN
                alu_res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                alu_res = sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                // diff[WIDTH] is the borrow, i.e. a < b unsigned
                alu_c = diff[WIDTH];
                alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
`ifdef ALU_SAT_EN
                alu_res = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
                alu_res = diff[WIDTH-1:0];
`endif
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_NOT:  alu_res = ~bus.a;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SHL:  alu_res = bus.a << bus.b[SHW-1:0];
            OP_SHR:  alu_res = bus.a >> bus.b[SHW-1:0];
            OP_MUL:  alu_res = '0;
            default: alu_e   = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = is_mul ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // a new op may be taken in the same cycle the result is consumed
                in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_d = is_mul ? ST_BUSY : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept && !is_mul) begin
            result_q <= alu_res;
            carry_q  <= alu_c;
            zero_q   <= (alu_res == '0);
            ovf_q    <= alu_v;
            err_q    <= alu_e;
        end else if (mul_done) begin
            result_q <= mul_product[WIDTH-1:0];
            carry_q  <= |mul_product[2*WIDTH-1:WIDTH];
            zero_q   <= (mul_product[WIDTH-1:0] == '0);
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_pipe
// Randomised self-checking bench for alu_pipe (WIDTH=8) against a reference model.
// Revision: 1.0
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        logic       e;
    } obs_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_pipe_if #(.WIDTH(8)) bus ();

    alu_pipe #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic obs_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        obs_t o;
        int sa, sb, s, ua, ub;
        o  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        case (op)
            4'd0: begin
                s     = ua + ub;
                o.c   = (s > 255);
                o.res = 8'(s);
                s     = sa + sb;
                o.v   = (s > 127) || (s < -128);
`ifdef ALU_SAT_EN
                if (o.c) o.res = 8'hFF;
`endif
            end
            4'd1: begin
                o.c   = (ua < ub);
                o.res = 8'(ua - ub);
                s     = sa - sb;
                o.v   = (s > 127) || (s < -128);
`ifdef ALU_SAT_EN
                if (o.c) o.res = 8'h00;
`endif
            end
            4'd2: o.res = a & b;
            4'd3: o.res = a | b;
            4'd4: o.res = ~a;
            4'd5: o.res = a ^ b;
            4'd6: o.res = 8'((ua * (1 << (ub % 8))) % 256);
            4'd7: o.res = 8'(ua / (1 << (ub % 8)));
            4'd8: begin
                s     = ua * ub;
                o.res = 8'(s % 256);
                o.c   = (s >= 256);
            end
            default: o.e = 1'b1;
        endcase
        o.z = (o.res == 8'h00);
        return o;
    endfunction

    function automatic obs_t observe();
        return {bus.result, bus.carry_out, bus.zero, bus.ovf, bus.err};
    endfunction

    // Issues one op with out_ready high; starts and ends just after a falling edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          output obs_t got, output int lat, output bit rdy_busy, output bit ok);
        int n;
        ok = 1'b1; rdy_busy = 1'b0; lat = 0; n = 0; got = '0;
        bus.a = a; bus.b = b; bus.opcode = op;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            ok = 1'b0;
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.opcode = 4'($urandom);
            do begin
                @(negedge clk);
                lat++;
                if (!bus.out_valid && bus.in_ready) rdy_busy = 1'b1;
            end while (!bus.out_valid && lat < 50);
            if (!bus.out_valid) ok = 1'b0;
            got = observe();
            @(posedge clk);
            #1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.opcode = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
            fails++;
        end
        tests++;
        if (observe() !== obs_t'(0)) begin
            $display("FAIL reset_outputs: got %h, required 000", observe());
            fails++;
        end
    endtask

    task automatic test_add();
        obs_t got, exp; int lat; bit rb, ok;
        run_op(8'hF0, 8'h20, 4'd0, got, lat, rb, ok);
        exp = model(8'hF0, 8'h20, 4'd0);
        tests++;
        if (!ok || got !== exp) begin
            $display("FAIL add: got %h, required %h (ok=%b)", got, exp, ok);
            fails++;
        end
        tests++;
        if (lat !== 1) begin
            $display("FAIL add_latency: got %0d, required 1", lat);
            fails++;
        end
    endtask

    task automatic test_sub();
        obs_t got, exp; int lat; bit rb, ok;
        run_op(8'h04, 8'h02, 4'd1, got, lat, rb, ok);
        exp = model(8'h04, 8'h02, 4'd1);
        tests++;
        if (!ok || got !== exp) begin
            $display("FAIL sub_basic: got %h, required %h", got, exp);
            fails++;
        end
        run_op(8'h80, 8'h01, 4'd1, got, lat, rb, ok);
        exp = model(8'h80, 8'h01, 4'd1);
        tests++;
        if (!ok || got !== exp) begin
            $display("FAIL sub_ovf: got %h, required %h", got, exp);
            fails++;
        end
    endtask

    task automatic test_mul();
        obs_t got, exp; int lat; bit rb, ok;
        run_op(8'd15, 8'd17, 4'd8, got, lat, rb, ok);
        exp = model(8'd15, 8'd17, 4'd8);
        tests++;
        if (!ok || got !== exp) begin
            $display("FAIL mul_15x17: got %h, required %h", got, exp);
            fails++;
        end
        tests++;
        if (lat !== 9) begin
            $display("FAIL mul_latency: got %0d, required 9", lat);
            fails++;
        end
        tests++;
        if (rb !== 1'b0) begin
            $display("FAIL mul_busy_ready: in_ready seen %b during busy, required 0", rb);
            fails++;
        end
        run_op(8'd16, 8'd16, 4'd8, got, lat, rb, ok);
        exp = model(8'd16, 8'd16, 4'd8);
        tests++;
        if (!ok || got !== exp) begin
            $display("FAIL mul_16x16: got %h, required %h", got, exp);
            fails++;
        end
    endtask

    task automatic test_backpressure();
        obs_t exp, exp2;
        exp  = model(8'hCC, 8'hAA, 4'd5);
        exp2 = model(8'h01, 8'h02, 4'd0);
        bus.a = 8'hCC; bus.b = 8'hAA; bus.opcode = 4'd5;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.opcode = 4'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || observe() !== exp) begin
                $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b got %h, required 1/0/%h",
                         i, bus.out_valid, bus.in_ready, observe(), exp);
                fails++;
            end
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.a = 8'h01; bus.b = 8'h02; bus.opcode = 4'd0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL backpressure_release_ready: got %b, required 1", bus.in_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || observe() !== exp2) begin
            $display("FAIL backpressure_next: valid=%b got %h, required 1/%h", bus.out_valid, observe(), exp2);
            fails++;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    task automatic test_illegal_shl();
        obs_t got, exp; int lat; bit rb, ok;
        run_op(8'h5A, 8'h3C, 4'hF, got, lat, rb, ok);
        exp = model(8'h5A, 8'h3C, 4'hF);
        tests++;
        if (!ok || got !== exp) begin
            $display("FAIL illegal_op: got %h, required %h", got, exp);
            fails++;
        end
        run_op(8'h01, 8'h0B, 4'd6, got, lat, rb, ok);
        exp = model(8'h01, 8'h0B, 4'd6);
        tests++;
        if (!ok || got !== exp) begin
            $display("FAIL shl: got %h, required %h", got, exp);
            fails++;
        end
    endtask

    task automatic test_reset_mid_mul();
        obs_t got, exp; int lat; bit rb, ok;
        run_op(8'h12, 8'h34, 4'd0, got, lat, rb, ok);
        bus.a = 8'hAB; bus.b = 8'hCD; bus.opcode = 4'd8;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || observe() !== obs_t'(0)) begin
            $display("FAIL reset_mid_mul_outputs: valid=%b got %h, required 0/000", bus.out_valid, observe());
            fails++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_mid_mul_ready: got %b, required 1", bus.in_ready);
            fails++;
        end
        repeat (10) @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || observe() !== obs_t'(0)) begin
            $display("FAIL reset_mid_mul_quiet: valid=%b got %h, required 0/000", bus.out_valid, observe());
            fails++;
        end
        run_op(8'd3, 8'd1, 4'd0, got, lat, rb, ok);
        exp = model(8'd3, 8'd1, 4'd0);
        tests++;
        if (!ok || got !== exp) begin
            $display("FAIL reset_mid_mul_next_add: got %h, required %h", got, exp);
            fails++;
        end
    endtask

    task automatic test_random();
        obs_t got, exp; int lat; bit rb, ok;
        logic [7:0] a, b; logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = (i % 5 == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            run_op(a, b, op, got, lat, rb, ok);
            exp = model(a, b, op);
            tests++;
            if (!ok || got !== exp || lat !== ((op == 4'd8) ? 9 : 1)) begin
                $display("FAIL random[%0d] op=%h a=%h b=%h: got %h lat %0d, required %h lat %0d",
                         i, op, a, b, got, lat, exp, (op == 4'd8) ? 9 : 1);
                fails++;
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp [6];
        logic [7:0] a, b; logic [3:0] op;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            do op = 4'($urandom); while (op == 4'd8);
            exp[i] = model(a, b, op);
            bus.a = a; bus.b = b; bus.opcode = op; bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i > 0) begin
                // the previous op's result must have been visible on the cycle just consumed
            end
            bus.in_valid = 1'b0;
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.opcode = 4'($urandom);
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || observe() !== exp[i]) begin
                $display("FAIL back_to_back[%0d]: valid=%b ready=%b got %h, required 1/1/%h",
                         i, bus.out_valid, bus.in_ready, observe(), exp[i]);
                fails++;
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

`ifdef ALU_SAT_EN
    task automatic test_sat();
        obs_t got; int lat; bit rb, ok;
        run_op(8'hF0, 8'h20, 4'd0, got, lat, rb, ok);
        tests++;
        if (!ok || got.res !== 8'hFF || got.c !== 1'b1) begin
            $display("FAIL sat_add: res=%h c=%b, required ff/1", got.res, got.c);
            fails++;
        end
        run_op(8'h02, 8'h04, 4'd1, got, lat, rb, ok);
        tests++;
        if (!ok || got.res !== 8'h00 || got.c !== 1'b1 || got.z !== 1'b1) begin
            $display("FAIL sat_sub: res=%h c=%b z=%b, required 00/1/1", got.res, got.c, got.z);
            fails++;
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_illegal_shl();
        test_reset_mid_mul();
        test_random();
        test_back_to_back();
`ifdef ALU_SAT_EN
        test_sat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
